// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux
//
// Purpose:
//   Time-multiplexes the four BCD digits of the stopwatch (min1 min0 : sec1 sec0)
//   onto a common-anode 4-digit seven-segment display. While adjust mode is on,
//   the digit pair being adjusted blinks. Every output is registered so the
//   block can drive board pins directly.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   BLINK_DIV    clock cycles per blink half-period (>= 2)
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   reset      in   asynchronous, active-high reset
//   min1       in   [3:0] tens-of-minutes BCD digit
//   min0       in   [3:0] units-of-minutes BCD digit
//   sec1       in   [3:0] tens-of-seconds BCD digit
//   sec0       in   [3:0] units-of-seconds BCD digit
//   adjust_en  in   1 = adjust mode, selected pair blinks
//   select     in   adjust target: 0 = minutes (an[3:2]), 1 = seconds (an[1:0])
//   an         out  [3:0] digit enables, active-low, an[0] = rightmost (sec0)
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low, held off
// -----------------------------------------------------------------------------
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic       adjust_en,
  input  logic       select,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q,         idx_d;
  logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    an_q,          an_d;
  logic [6:0]    seg_q,         seg_d;
  logic          dp_q;

  logic [3:0]    digit;
  logic          in_pair;
  logic          blank;

  // Scan timing: idx steps on the last cycle of each refresh slot.
  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (refresh_cnt_q == REFRESH_MAX) begin
      refresh_cnt_d = '0;
      idx_d         = idx_q + 2'd1;
    end
  end

  // Blink timing: held cleared outside adjust mode so entering it always
  // starts with a full visible half-period.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (adjust_en) begin
      blink_cnt_d   = blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end
    end
  end

  // Output path: digit select, decode and blanking, loaded every clock.
  always_comb begin
    case (idx_q)
      2'd0:    digit = sec0;
      2'd1:    digit = sec1;
      2'd2:    digit = min0;
      default: digit = min1;
    endcase

    // idx[1] is 0 for the seconds pair and 1 for the minutes pair; select
    // uses the opposite encoding, so the pair matches when they differ.
    in_pair = idx_q[1] ^ select;
    blank   = adjust_en & blink_phase_q & in_pair;

    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = decode(digit);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_display_mux
//
// Directed bench for seg_display_mux with REFRESH_DIV=4 and BLINK_DIV=8.
// Outputs are sampled 1 time unit after each rising edge; inputs are changed
// at that same point so they are stable well before the next edge.
// -----------------------------------------------------------------------------
module tb_seg_display_mux;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] min1, min0, sec1, sec0;
  logic       adjust_en, select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int pos    = 0;  // rising edges since the last reset release
  int ac     = 0;  // consecutive rising edges seen with adjust_en = 1

  logic [6:0] dec_tbl [16];

  seg_display_mux #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .min1      (min1),
    .min0      (min0),
    .sec1      (sec1),
    .sec0      (sec0),
    .adjust_en (adjust_en),
    .select    (select),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    assert ({an, seg, dp} === {exp_an, exp_seg, 1'b1})
      else begin
        errors++;
        $error("FAIL %s: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
               tag, an, seg, dp, exp_an, exp_seg);
      end
  endtask

  function automatic logic [3:0] digit_at(input int i);
    case (i)
      0:       digit_at = sec0;
      1:       digit_at = sec1;
      2:       digit_at = min0;
      default: digit_at = min1;
    endcase
  endfunction

  // Advance one clock and compare against the expected scan/blink position.
  // Output at edge n reflects the slot (n-1)/REFRESH_DIV and the blink phase
  // accumulated over the previous enabled edges.
  task automatic step(input string tag);
    int         i;
    logic       blank;
    logic [3:0] ea;
    @(posedge clk);
    #1;
    pos++;
    if (adjust_en) ac++;
    else           ac = 0;
    i     = ((pos - 1) / REFRESH_DIV) % 4;
    blank = adjust_en && (((ac - 1) / BLINK_DIV) % 2 == 1) &&
            ((select && i < 2) || (!select && i >= 2));
    ea    = blank ? 4'b1111 : ~(4'b0001 << i);
    check(tag, ea, dec_tbl[digit_at(i)]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dec_tbl[0]  = 7'b1000000;  dec_tbl[1]  = 7'b1111001;
    dec_tbl[2]  = 7'b0100100;  dec_tbl[3]  = 7'b0110000;
    dec_tbl[4]  = 7'b0011001;  dec_tbl[5]  = 7'b0010010;
    dec_tbl[6]  = 7'b0000010;  dec_tbl[7]  = 7'b1111000;
    dec_tbl[8]  = 7'b0000000;  dec_tbl[9]  = 7'b0010000;
    for (int k = 10; k < 16; k++) dec_tbl[k] = 7'b1111111;

    // ---- Reset and basic scan order --------------------------------------
    reset = 1'b1;
    min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
    adjust_en = 1'b0; select = 1'b0;
    #3;
    check("reset_async", 4'b1111, 7'b1111111);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 4'b1111, 7'b1111111);
    reset = 1'b0;
    pos = 0; ac = 0;

    step("scan");
    check("rst_first_sec0", 4'b1110, 7'b0011001);
    for (int c = 2; c <= 17; c++) begin
      step("scan");
      if (c == 5)  check("scan_sec1", 4'b1101, 7'b0110000);
      if (c == 9)  check("scan_min0", 4'b1011, 7'b0100100);
      if (c == 13) check("scan_min1", 4'b0111, 7'b1111001);
      if (c == 17) check("scan_wrap", 4'b1110, 7'b0011001);
    end

    // ---- Decode sweep on sec0 while idx = 0 ------------------------------
    for (int v = 0; v < 16; v++) begin
      while ((pos % 16) >= 4) step("sweep_scan");
      sec0 = 4'(v);
      step("dec_sweep");
      check($sformatf("dec_%0d", v), 4'b1110, dec_tbl[v]);
    end

    // ---- Blink seconds ---------------------------------------------------
    min1 = 4'd5; min0 = 4'd9; sec1 = 4'd5; sec0 = 4'd9;
    while ((pos % 16) != 6) step("pre_blink");
    adjust_en = 1'b1;
    select    = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step("blink_sec");
      if (c == 8)  check("blink_sec_vis_min1", 4'b0111, 7'b0010010);
      if (c == 9)  check("blink_sec_min1_on",  4'b0111, 7'b0010010);
      if (c == 11) check("blink_sec_sec0_off", 4'b1111, 7'b0010000);
      if (c == 15) check("blink_sec_sec1_off", 4'b1111, 7'b0010010);
      if (c == 17) check("blink_sec_sec1_on",  4'b1101, 7'b0010010);
    end

    // ---- Blink minutes, flip select, leave adjust ------------------------
    select = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step("blink_min");
      if (c == 9)  check("blink_min_min1_off", 4'b1111, 7'b0010010);
      if (c == 11) check("blink_min_sec0_on",  4'b1110, 7'b0010000);
    end
    select = 1'b1;
    step("blink_flip");
    check("blink_flip_sec0_off", 4'b1111, 7'b0010000);
    for (int c = 2; c <= 16; c++) step("blink_hold");
    check("blink_hold_sec0_off", 4'b1111, 7'b0010000);
    adjust_en = 1'b0;
    step("unblink");
    check("unblink_sec0_on", 4'b1110, 7'b0010000);
    for (int c = 1; c <= 5; c++) step("unblink");

    // Re-entering adjust mode starts in the visible phase.
    adjust_en = 1'b1;
    for (int c = 1; c <= 8; c++) step("reenter_visible");
    adjust_en = 1'b0;
    step("reenter_off");

    // ---- Asynchronous reset mid-scan at idx = 2 ---------------------------
    while ((((pos - 1) % 16) / 4) != 2) step("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_async", 4'b1111, 7'b1111111);
    @(posedge clk);
    #1;
    check("rst_mid_hold", 4'b1111, 7'b1111111);
    reset = 1'b0;
    pos = 0; ac = 0;
    step("post_rst");
    check("post_rst_first", 4'b1110, 7'b0010000);

    // ---- Live update of sec0 while idx = 0 -------------------------------
    sec0 = 4'd8;
    step("live");
    check("live_sec0_8", 4'b1110, 7'b0000000);
    sec0 = 4'd9;
    step("live");
    check("live_sec0_9", 4'b1110, 7'b0010000);
    for (int c = 4; c <= 17; c++) begin
      step("cadence");
      if (pos == 5)  check("cadence_sec1", 4'b1101, 7'b0010010);
      if (pos == 17) check("cadence_wrap", 4'b1110, 7'b0010000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream consumer of the stopwatch counter's four BCD digits (min1, min0, sec1, sec0).
- Time-multiplexes the digits onto a common-anode 4-digit seven-segment display.
- Blinks the digit pair currently being adjusted.
- Sits between the counter and the board pins; all outputs are registered.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit (100 MHz gives 1 kHz digit rate, 250 Hz per digit).
- BLINK_DIV, 25000000: clock cycles per blink half-period (100 MHz gives 2 Hz blink).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- min1  input  4  tens-of-minutes BCD digit.
- min0  input  4  units-of-minutes BCD digit.
- sec1  input  4  tens-of-seconds BCD digit.
- sec0  input  4  units-of-seconds BCD digit.
- adjust_en  input  1  1 = adjust mode; selected pair blinks.
- select  input  1  adjust target: 0 = minutes (an[3:2]), 1 = seconds (an[1:0]).
- an  output  4  digit enables, active-low; an[0] = rightmost digit (sec0), an[3] = min1.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (asynchronous, active-high):
  - refresh_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Asserting reset mid-scan returns all of the above immediately, with no wait for a clock edge.
- refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cycle where refresh_cnt == REFRESH_DIV-1, idx advances 0→1→2→3→0.
  - Each idx value therefore lasts exactly REFRESH_DIV cycles.
- Digit mapping: idx 0 → sec0, 1 → sec1, 2 → min0, 3 → min1.
- Output registers are loaded every clock from the current idx and current inputs. Latency is one cycle from an idx or input change to an/seg.
  - an = ~(1 << idx), unless blanked (see below).
  - seg = decode(digit[idx]).
- Decode (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Values 10–15 produce 1111111 (blank); no error flag.
- Blink counter:
  - While adjust_en = 0: blink_cnt and blink_phase are held at 0.
  - While adjust_en = 1: blink_cnt counts 0..BLINK_DIV-1; on wrap, blink_phase toggles.
- Blanking:
  - Condition: adjust_en = 1, blink_phase = 1, and idx belongs to the selected pair (select = 0: idx 2,3; select = 1: idx 0,1).
  - When the condition holds, the registered an = 4'b1111. seg still carries the decoded value.
- Entering adjust mode: adjust_en 0→1 starts with blink_phase = 0, so digits are shown for a full BLINK_DIV cycles before the first blank.
- Changing select mid-blink: takes effect on the next clock; blink_cnt and blink_phase are not reset.
- Leaving adjust mode: adjust_en 1→0 clears the blink state on the next clock, so digits are visible again one cycle later.
- Input digits may change on any cycle, including mid-digit. The new value appears on seg one cycle later without disturbing the scan.
- REFRESH_DIV and BLINK_DIV must be ≥ 2. Counter widths are $clog2 of the divisor; no overflow is possible.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8 in simulation):
- Reset: hold reset with min1..sec0 = 1,2,3,4, then release.
  - One clock after release: an = 1110, seg = 0011001 (4).
  - an = 1101 / seg = 0110000 (3) starts 4 cycles later; then 1011 / 0100100 (2); then 0111 / 1111001 (1); then wraps back to 1110.
- Decode sweep: drive sec0 through 0..15 while idx = 0.
  - Each seg matches the table one cycle after the change.
  - 10–15 give 1111111.
- Blink seconds: adjust_en = 1, select = 1, digits 5,9,5,9.
  - Cycles 1–8 after the enable: all four digits scan normally.
  - Cycles 9–16: an = 1111 whenever idx is 0 or 1; an[3:2] still scan.
  - Pattern repeats every 16 cycles.
- Blink minutes with mid-run changes:
  - select = 0: blanking applies to idx 2,3.
  - Flip select to 1 while blink_phase = 1: blanking moves to idx 0,1 on the next clock.
  - Drop adjust_en: no blanking one cycle later, blink_phase = 0.
- Async reset mid-scan: assert reset at idx = 2 between clock edges.
  - an = 1111 and seg = 1111111 immediately.
  - After release, scanning restarts at an = 1110.
- Live update: change sec0 from 8 to 9 while idx = 0.
  - seg goes 0000000 → 0010000 one cycle later.
  - Refresh cadence is unchanged.
